// File: rtl/pipeline_ctrl_pkg.sv
// Shared constants and state encoding for the KANADE32 stage sequencer.
package kanade32_pipe_pkg;

  localparam int MODE_SEQ  = 0;
  localparam int MODE_PIPE = 1;
  localparam int REG_ZERO  = 0;
  localparam int WAIT_W    = 3;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB
  } seq_state_t;

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Read-after-write hazard check of the decode sources against the three
// in-flight destinations; register zero is hardwired and never conflicts.
module hazard_detect
  import kanade32_pipe_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic [REG_AW-1:0] ex_dst,
  input  logic              ex_reg_write,
  input  logic [REG_AW-1:0] mem_dst,
  input  logic              mem_reg_write,
  input  logic [REG_AW-1:0] wb_dst,
  input  logic              wb_reg_write,
  output logic              hazard
);

  function automatic logic src_hit(input logic [REG_AW-1:0] src,
                                   input logic [REG_AW-1:0] dst,
                                   input logic              we);
    return we && (dst != REG_AW'(REG_ZERO)) && (src == dst);
  endfunction

  logic rs_hit;
  logic rt_hit;

  always_comb begin
    rs_hit = id_uses_rs && (src_hit(id_rs, ex_dst, ex_reg_write) ||
                            src_hit(id_rs, mem_dst, mem_reg_write) ||
                            src_hit(id_rs, wb_dst, wb_reg_write));
    rt_hit = id_uses_rt && (src_hit(id_rt, ex_dst, ex_reg_write) ||
                            src_hit(id_rt, mem_dst, mem_reg_write) ||
                            src_hit(id_rt, wb_dst, wb_reg_write));
    hazard = rs_hit || rt_hit;
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Stage-enable / RAM-port sequencer for the FD/DE/EM/MW/WB pipeline, either
// one stage per cycle (MODE_SEQ) or fully pipelined with interlocks (MODE_PIPE).
//
// state    | meaning
// S_FETCH  | load FD from RAM at PC
// S_DECODE | load DE
// S_EXEC   | load EM
// S_MEM    | RAM addressed by MW ALU result, held MEM_LAT cycles on access
// S_WB     | regfile write and PC update
module pipeline_ctrl
  import kanade32_pipe_pkg::*;
#(
  parameter int MODE    = 1,
  parameter int REG_AW  = 5,
  parameter int MEM_LAT = 1,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic [REG_AW-1:0] ex_dst,
  input  logic              ex_reg_write,
  input  logic [REG_AW-1:0] mem_dst,
  input  logic              mem_reg_write,
  input  logic [REG_AW-1:0] wb_dst,
  input  logic              wb_reg_write,
  input  logic              mem_access,
  input  logic              mem_write,
  input  logic              redirect,
  output logic              pc_wren,
  output logic              fd_wren,
  output logic              de_wren,
  output logic              em_wren,
  output logic              mw_wren,
  output logic              reg_wren,
  output logic              mem_wren,
  output logic              ram_addr_src,
  output logic              fd_flush,
  output logic              de_flush,
  output logic              em_flush,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(MEM_LAT - 1);

  seq_state_t        state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0]  stall_q;
  logic              hazard;

  hazard_detect #(.REG_AW(REG_AW)) u_hazard (
    .id_rs         (id_rs),
    .id_rt         (id_rt),
    .id_uses_rs    (id_uses_rs),
    .id_uses_rt    (id_uses_rt),
    .ex_dst        (ex_dst),
    .ex_reg_write  (ex_reg_write),
    .mem_dst       (mem_dst),
    .mem_reg_write (mem_reg_write),
    .wb_dst        (wb_dst),
    .wb_reg_write  (wb_reg_write),
    .hazard        (hazard)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_FETCH;
      wait_q  <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (MODE == MODE_PIPE && !pc_wren && !(&stall_q))
        stall_q <= stall_q + CNT_W'(1);
    end
  end

  assign stall_cnt = stall_q;

  // Outputs are also gated by reset_n so an access in flight when reset
  // arrives can never strobe the RAM.
  always_comb begin
    state_d      = state_q;
    wait_d       = wait_q;
    pc_wren      = 1'b0;
    fd_wren      = 1'b0;
    de_wren      = 1'b0;
    em_wren      = 1'b0;
    mw_wren      = 1'b0;
    reg_wren     = 1'b0;
    mem_wren     = 1'b0;
    ram_addr_src = 1'b0;
    fd_flush     = 1'b0;
    de_flush     = 1'b0;
    em_flush     = 1'b0;

    if (!reset_n) begin
      fd_flush = 1'b1;
      de_flush = 1'b1;
      em_flush = 1'b1;
    end else if (MODE == MODE_SEQ) begin
      case (state_q)
        S_FETCH: begin
          fd_wren = 1'b1;
          state_d = S_DECODE;
        end
        S_DECODE: begin
          de_wren = 1'b1;
          state_d = S_EXEC;
        end
        S_EXEC: begin
          em_wren = 1'b1;
          state_d = S_MEM;
        end
        S_MEM: begin
          ram_addr_src = 1'b1;
          if (!mem_access) begin
            mw_wren = 1'b1;
            state_d = S_WB;
          end else if (wait_q == LAST_WAIT) begin
            mw_wren  = 1'b1;
            mem_wren = mem_write;
            wait_d   = '0;
            state_d  = S_WB;
          end else begin
            wait_d = wait_q + WAIT_W'(1);
          end
        end
        S_WB: begin
          reg_wren = 1'b1;
          pc_wren  = 1'b1;
          state_d  = S_FETCH;
        end
        default: state_d = S_FETCH;
      endcase
    end else begin
      pc_wren  = 1'b1;
      fd_wren  = 1'b1;
      de_wren  = 1'b1;
      em_wren  = 1'b1;
      mw_wren  = 1'b1;
      reg_wren = 1'b1;

      if (mem_access && wait_q < LAST_WAIT) begin
        pc_wren      = 1'b0;
        fd_wren      = 1'b0;
        de_wren      = 1'b0;
        em_wren      = 1'b0;
        mw_wren      = 1'b0;
        reg_wren     = 1'b0;
        ram_addr_src = 1'b1;
        wait_d       = wait_q + WAIT_W'(1);
      end else if (mem_access) begin
        // RAM port is busy with the data access, so the fetch is replayed.
        ram_addr_src = 1'b1;
        mem_wren     = mem_write;
        wait_d       = '0;
        pc_wren      = 1'b0;
        fd_wren      = 1'b0;
        de_flush     = 1'b1;
        if (redirect) begin
          pc_wren  = 1'b1;
          fd_flush = 1'b1;
          em_flush = 1'b1;
        end
      end else if (redirect) begin
        fd_flush = 1'b1;
        de_flush = 1'b1;
        em_flush = 1'b1;
      end else if (hazard) begin
        pc_wren  = 1'b0;
        fd_wren  = 1'b0;
        de_flush = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed checks of the sequencer: instance 0 = MODE 0/MEM_LAT 1,
// instance 1 = MODE 0/MEM_LAT 3, instance 2 = MODE 1/MEM_LAT 2.
module tb_pipeline_ctrl;

  localparam int AW = 5;
  localparam int CW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n;
  logic [AW-1:0] id_rs, id_rt, ex_dst, mem_dst, wb_dst;
  logic          id_uses_rs, id_uses_rt, ex_reg_write, mem_reg_write, wb_reg_write;
  logic          mem_access, mem_write, redirect;

  logic          pc_wren [3];
  logic          fd_wren [3];
  logic          de_wren [3];
  logic          em_wren [3];
  logic          mw_wren [3];
  logic          reg_wren [3];
  logic          mem_wren [3];
  logic          ram_addr_src [3];
  logic          fd_flush [3];
  logic          de_flush [3];
  logic          em_flush [3];
  logic [CW-1:0] stall_cnt [3];

  int n_cmp = 0;
  int n_err = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    pipeline_ctrl #(
      .MODE    ((g == 2) ? 1 : 0),
      .REG_AW  (AW),
      .MEM_LAT ((g == 0) ? 1 : ((g == 1) ? 3 : 2)),
      .CNT_W   (CW)
    ) u_dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .id_rs         (id_rs),
      .id_rt         (id_rt),
      .id_uses_rs    (id_uses_rs),
      .id_uses_rt    (id_uses_rt),
      .ex_dst        (ex_dst),
      .ex_reg_write  (ex_reg_write),
      .mem_dst       (mem_dst),
      .mem_reg_write (mem_reg_write),
      .wb_dst        (wb_dst),
      .wb_reg_write  (wb_reg_write),
      .mem_access    (mem_access),
      .mem_write     (mem_write),
      .redirect      (redirect),
      .pc_wren       (pc_wren[g]),
      .fd_wren       (fd_wren[g]),
      .de_wren       (de_wren[g]),
      .em_wren       (em_wren[g]),
      .mw_wren       (mw_wren[g]),
      .reg_wren      (reg_wren[g]),
      .mem_wren      (mem_wren[g]),
      .ram_addr_src  (ram_addr_src[g]),
      .fd_flush      (fd_flush[g]),
      .de_flush      (de_flush[g]),
      .em_flush      (em_flush[g]),
      .stall_cnt     (stall_cnt[g])
    );
  end

  // {pc, fd, de, em, mw, reg}
  function automatic logic [31:0] en(input int i);
    return {26'd0, pc_wren[i], fd_wren[i], de_wren[i], em_wren[i], mw_wren[i], reg_wren[i]};
  endfunction

  // {fd, de, em}
  function automatic logic [31:0] fl(input int i);
    return {29'd0, fd_flush[i], de_flush[i], em_flush[i]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  logic [31:0] rot [5];

  initial begin
    rot[0] = 32'h10; rot[1] = 32'h08; rot[2] = 32'h04; rot[3] = 32'h02; rot[4] = 32'h21;

    reset_n = 1'b0;
    id_rs = '0; id_rt = '0; ex_dst = '0; mem_dst = '0; wb_dst = '0;
    id_uses_rs = 1'b0; id_uses_rt = 1'b0;
    ex_reg_write = 1'b0; mem_reg_write = 1'b0; wb_reg_write = 1'b0;
    mem_access = 1'b0; mem_write = 1'b0; redirect = 1'b0;
    tick();
    tick();

    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_en_%0d", i), en(i), 32'h0);
      chk($sformatf("rst_flush_%0d", i), fl(i), 32'h7);
      chk($sformatf("rst_ras_%0d", i), 32'(ram_addr_src[i]), 32'h0);
      chk($sformatf("rst_stall_%0d", i), 32'(stall_cnt[i]), 32'h0);
    end

    // Sequential rotation, no data access
    reset_n = 1'b1;
    settle();
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("seq1_en_c%0d", i), en(0), rot[i % 5]);
      chk($sformatf("seq3_en_c%0d", i), en(1), rot[i % 5]);
      chk($sformatf("seq1_ras_c%0d", i), 32'(ram_addr_src[0]), (i % 5 == 3) ? 32'h1 : 32'h0);
      chk($sformatf("seq1_flush_c%0d", i), fl(0), 32'h0);
      chk($sformatf("pipe_en_c%0d", i), en(2), 32'h3F);
      tick();
    end
    chk("seq1_stall", 32'(stall_cnt[0]), 32'h0);
    chk("pipe_stall_idle", 32'(stall_cnt[2]), 32'h0);

    // Sequential store with MEM_LAT 3
    tick(); tick(); tick();
    mem_access = 1'b1; mem_write = 1'b1;
    settle();
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("seq3_ras_m%0d", c), 32'(ram_addr_src[1]), 32'h1);
      chk($sformatf("seq3_mw_m%0d", c), 32'(mw_wren[1]), (c == 2) ? 32'h1 : 32'h0);
      chk($sformatf("seq3_memw_m%0d", c), 32'(mem_wren[1]), (c == 2) ? 32'h1 : 32'h0);
      tick();
    end
    chk("seq3_wb_en", en(1), 32'h21);
    chk("seq3_wb_ras", 32'(ram_addr_src[1]), 32'h0);
    mem_access = 1'b0; mem_write = 1'b0;

    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;

    // Data hazards
    id_rs = 5; id_uses_rs = 1'b1; ex_dst = 5; ex_reg_write = 1'b1;
    settle();
    chk("haz_ex_en", en(2), 32'h0F);
    chk("haz_ex_flush", fl(2), 32'h2);
    chk("haz_ex_stall_pre", 32'(stall_cnt[2]), 32'h0);
    tick();
    chk("haz_ex_stall", 32'(stall_cnt[2]), 32'h1);
    ex_dst = 0;
    settle();
    chk("haz_zero_en", en(2), 32'h3F);
    chk("haz_zero_flush", fl(2), 32'h0);
    tick();
    chk("haz_zero_stall", 32'(stall_cnt[2]), 32'h1);
    ex_reg_write = 1'b0; id_uses_rs = 1'b0;
    id_rt = 7; id_uses_rt = 1'b1; mem_dst = 7; mem_reg_write = 1'b1;
    settle();
    chk("haz_mem_rt_en", en(2), 32'h0F);
    tick();
    chk("haz_mem_rt_stall", 32'(stall_cnt[2]), 32'h2);
    mem_reg_write = 1'b0; id_uses_rt = 1'b0;
    id_rs = 9; wb_dst = 9; wb_reg_write = 1'b1;
    settle();
    chk("haz_unused_rs_en", en(2), 32'h3F);
    id_uses_rs = 1'b1;
    settle();
    chk("haz_wb_en", en(2), 32'h0F);
    tick();
    chk("haz_wb_stall", 32'(stall_cnt[2]), 32'h3);
    wb_reg_write = 1'b0; id_uses_rs = 1'b0;

    // Load with MEM_LAT 2
    mem_access = 1'b1; mem_write = 1'b0;
    settle();
    chk("ld_wait_en", en(2), 32'h0);
    chk("ld_wait_ras", 32'(ram_addr_src[2]), 32'h1);
    chk("ld_wait_flush", fl(2), 32'h0);
    tick();
    chk("ld_wait_stall", 32'(stall_cnt[2]), 32'h4);
    chk("ld_last_en", en(2), 32'h0F);
    chk("ld_last_flush", fl(2), 32'h2);
    chk("ld_last_ras", 32'(ram_addr_src[2]), 32'h1);
    chk("ld_last_memw", 32'(mem_wren[2]), 32'h0);
    tick();
    chk("ld_stall", 32'(stall_cnt[2]), 32'h5);
    mem_access = 1'b0;
    settle();
    chk("ld_after_en", en(2), 32'h3F);
    chk("ld_after_ras", 32'(ram_addr_src[2]), 32'h0);

    // Store whose final cycle meets a redirect
    mem_access = 1'b1; mem_write = 1'b1;
    settle();
    chk("st_wait_en", en(2), 32'h0);
    chk("st_wait_memw", 32'(mem_wren[2]), 32'h0);
    tick();
    redirect = 1'b1;
    settle();
    chk("st_redir_en", en(2), 32'h2F);
    chk("st_redir_flush", fl(2), 32'h7);
    chk("st_redir_memw", 32'(mem_wren[2]), 32'h1);
    tick();
    chk("st_redir_stall", 32'(stall_cnt[2]), 32'h6);
    mem_access = 1'b0; mem_write = 1'b0; redirect = 1'b0;

    // Redirect beats a data hazard
    id_rs = 5; id_uses_rs = 1'b1; ex_dst = 5; ex_reg_write = 1'b1; redirect = 1'b1;
    settle();
    chk("redir_haz_en", en(2), 32'h3F);
    chk("redir_haz_flush", fl(2), 32'h7);
    tick();
    chk("redir_haz_stall", 32'(stall_cnt[2]), 32'h6);
    redirect = 1'b0;
    settle();
    chk("redir_off_flush", fl(2), 32'h2);
    chk("redir_off_en", en(2), 32'h0F);

    // Saturation of stall_cnt under a persistent hazard
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    settle();
    chk("sat_start", 32'(stall_cnt[2]), 32'h0);
    repeat (65534) tick();
    chk("sat_fffe", 32'(stall_cnt[2]), 32'hFFFE);
    tick();
    chk("sat_ffff", 32'(stall_cnt[2]), 32'hFFFF);
    tick(); tick();
    chk("sat_hold", 32'(stall_cnt[2]), 32'hFFFF);

    mem_access = 1'b1; mem_write = 1'b1; reset_n = 1'b0;
    settle();
    chk("rst_abort_memw", 32'(mem_wren[2]), 32'h0);
    tick();
    chk("final_rst_stall", 32'(stall_cnt[2]), 32'h0);
    chk("final_rst_flush", fl(2), 32'h7);
    chk("final_rst_en", en(2), 32'h0);
    chk("final_rst_seq_flush", fl(1), 32'h7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Parametrised successor to the fixed multi-cycle stage sequencer in the KANADE32 core.
- Generates per-stage write enables and the RAM address select for the FD/DE/EM/MW/WB pipeline.
- Adds a fully pipelined mode with data-hazard interlock, structural-hazard arbitration of the single RAM port, multi-cycle memory wait, branch/jump flush and a stall counter.
- Sits beside the stage registers, regfile and PC in the core top.

Parameters:
- MODE, 1, 0 = sequential (one stage per cycle), 1 = pipelined with interlocks
- REG_AW, 5, register-index width
- MEM_LAT, 1, RAM access cycles per data access, legal 1..4
- CNT_W, 16, stall counter width

Ports:
- clk  in  1  core clock
- reset_n  in  1  synchronous, active-low reset
- id_rs  in  REG_AW  rs index of instruction in decode
- id_rt  in  REG_AW  rt index of instruction in decode
- id_uses_rs  in  1  decode instruction reads rs
- id_uses_rt  in  1  decode instruction reads rt
- ex_dst  in  REG_AW  destination of EM-stage instruction
- ex_reg_write  in  1  EM-stage instruction writes a register
- mem_dst  in  REG_AW  destination of MW-stage instruction
- mem_reg_write  in  1  MW-stage instruction writes a register
- wb_dst  in  REG_AW  destination of WB-stage instruction
- wb_reg_write  in  1  WB-stage instruction writes a register
- mem_access  in  1  MW-stage instruction reads or writes RAM
- mem_write  in  1  MW-stage instruction is a store
- redirect  in  1  MW stage resolved a taken branch or jump
- pc_wren, fd_wren, de_wren, em_wren, mw_wren  out  1 each  stage-register enables
- reg_wren  out  1  regfile write-slot enable
- mem_wren  out  1  RAM write strobe
- ram_addr_src  out  1  0 = RAM address from PC, 1 = from MW ALU result
- fd_flush, de_flush, em_flush  out  1 each  load bubble into that stage register on the next edge
- stall_cnt  out  CNT_W  saturating count of cycles with pc_wren = 0 (MODE 1 only)

Behaviour:
- Reset (reset_n = 0 at a clk edge):
  - All enables, mem_wren and ram_addr_src go to 0; all flush outputs go to 1.
  - stall_cnt goes to 0; the wait counter goes to 0; the sequential state goes to S_FETCH.
  - Reset asserted mid-access aborts the access with no mem_wren.
- MODE 0, states S_FETCH > S_DECODE > S_EXEC > S_MEM > S_WB > S_FETCH:
  - S_FETCH: fd_wren = 1.
  - S_DECODE: de_wren = 1.
  - S_EXEC: em_wren = 1.
  - S_MEM: ram_addr_src = 1. If mem_access, hold S_MEM for MEM_LAT cycles and assert mw_wren on the last one, together with mem_wren when mem_write. Otherwise S_MEM lasts 1 cycle.
  - S_WB: reg_wren = 1, pc_wren = 1 (PC loads the next-PC mux, which already covers redirect).
  - Flush outputs are 0 after reset. Hazard inputs are ignored. stall_cnt stays at 0.
- MODE 1: default each cycle is every enable = 1, ram_addr_src = 0, all flush outputs = 0. Overrides are evaluated in priority order:
  1. Memory wait. mem_access and wait count < MEM_LAT-1:
     - All enables = 0, ram_addr_src = 1, the wait counter increments.
  2. Memory final cycle. mem_access and wait count = MEM_LAT-1:
     - ram_addr_src = 1, mem_wren = mem_write, the wait counter clears.
     - Fetch slot is lost: pc_wren = 0, fd_wren = 0.
     - Downstream advances: de_wren, em_wren, mw_wren and reg_wren = 1.
     - de_flush = 1, so a bubble enters DE and the held FD instruction decodes again next cycle.
  3. Redirect (only when no memory wait is active):
     - pc_wren = 1, and fd_flush, de_flush, em_flush = 1 for exactly one cycle.
     - A redirect coinciding with case 2 is honoured in the same cycle with the same flushes, and pc_wren is forced to 1.
  4. Data hazard:
     - Condition: (id_uses_rs and id_rs matches) or (id_uses_rt and id_rt matches) any of ex_dst, mem_dst or wb_dst whose reg_write is set and whose index is nonzero.
     - Response: pc_wren = 0, fd_wren = 0, de_flush = 1. EM, MW and WB advance.
     - Index 0 never causes a hazard.
     - A redirect in the same cycle wins over the hazard.
- stall_cnt increments on every non-reset cycle with pc_wren = 0 and saturates at all-ones.
- All outputs are registered-state driven combinational decodes. There is no extra latency: a hazard visible in cycle N suppresses pc_wren in cycle N.
- MEM_LAT = 1 means no wait cycles, so case 2 applies on the first cycle of the access.

Decomposition:
- Shared package kanade32_pipe_pkg holds:
  - MODE_SEQ = 0 and MODE_PIPE = 1
  - the state enum S_FETCH..S_WB
  - REG_ZERO = 0
- One natural sub-module, hazard_detect: combinational, compares the decode sources against the three destinations and outputs hazard.

Test Plan:
- MODE 0, MEM_LAT 1, no mem_access, reset released -> enables rotate fd, de, em, mw, reg+pc over 5 cycles, and pc_wren pulses every 5th cycle.
- MODE 0, MEM_LAT 3, store in S_MEM -> ram_addr_src = 1 for 3 cycles, with mw_wren and mem_wren high only on the 3rd.
- MODE 1, id_rs = 5, id_uses_rs = 1, ex_dst = 5, ex_reg_write = 1 -> pc_wren = 0, fd_wren = 0, de_flush = 1, stall_cnt += 1. With ex_dst = 0 instead, no stall occurs.
- MODE 1, MEM_LAT 2, load in MW -> cycle 1: all enables 0. Cycle 2: de, em, mw and reg enables = 1, pc/fd = 0, de_flush = 1. stall_cnt += 2.
- MODE 1, redirect = 1 together with a data hazard -> pc_wren = 1, fd/de/em flush = 1 for one cycle, stall_cnt unchanged.
- MODE 1, stall_cnt preloaded to 0xFFFE by 65534 hazard cycles, then 3 more -> holds at 0xFFFF. reset_n = 0 at the next edge -> 0, and all flush outputs = 1.
